// File: rtl/jb_xssi_pkg.sv
// Shared types and default widths for the multi-channel xSSI window counter.
package jb_xssi_pkg;

  localparam int unsigned DefNumCh      = 4;
  localparam int unsigned DefRssiTicsBw = 21;
  localparam int unsigned DefWinIdxBw   = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ch_state_e;

endpackage

// File: rtl/jb_xssi_multi_cntr_if.sv
// Control and status bundle of the multi-channel xSSI window counter.
interface jb_xssi_multi_cntr_if
  import jb_xssi_pkg::*;
#(
  parameter int unsigned NUM_CH           = DefNumCh,
  parameter int unsigned MAX_RSSI_TICS_BW = DefRssiTicsBw,
  parameter int unsigned WIN_IDX_BW       = DefWinIdxBw
);

  logic [NUM_CH-1:0][MAX_RSSI_TICS_BW-1:0] ch_num_tics;
  logic [NUM_CH-1:0]                       ch_oneshot;
  logic [NUM_CH-1:0]                       ch_start;
  logic [NUM_CH-1:0]                       ch_stop;
  logic                                    sync_in;
  logic [NUM_CH-1:0]                       rssi_load;
  logic [NUM_CH-1:0]                       ch_busy;
  logic [NUM_CH-1:0]                       ch_done;
  logic [NUM_CH-1:0][WIN_IDX_BW-1:0]       win_idx;

  modport master (
    output ch_num_tics, ch_oneshot, ch_start, ch_stop, sync_in,
    input  rssi_load, ch_busy, ch_done, win_idx
  );

  modport slave (
    input  ch_num_tics, ch_oneshot, ch_start, ch_stop, sync_in,
    output rssi_load, ch_busy, ch_done, win_idx
  );

endinterface

// File: rtl/jb_xssi_ch_cntr.sv
// One xSSI window channel: counts N-tic windows, pulses rssi_load at each window end.
module jb_xssi_ch_cntr
  import jb_xssi_pkg::*;
#(
  parameter int unsigned MAX_RSSI_TICS_BW = DefRssiTicsBw,
  parameter int unsigned WIN_IDX_BW       = DefWinIdxBw
) (
  input  logic                        clk_15p36,
  input  logic                        reset_15p36,
  input  logic [MAX_RSSI_TICS_BW-1:0] num_tics_i,
  input  logic                        oneshot_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        sync_i,
  output logic                        rssi_load_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [WIN_IDX_BW-1:0]       win_idx_o
);

  ch_state_e                   state_q, state_d;
  logic [MAX_RSSI_TICS_BW-1:0] n_q, n_d;
  logic [MAX_RSSI_TICS_BW-1:0] cnt_q, cnt_d;
  logic [WIN_IDX_BW-1:0]       idx_q, idx_d;
  logic                        start_ok;
  logic                        win_end;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rssi_load_o = 1'b0;
    // A start with a zero length is not a request at all, in any state.
    start_ok    = start_i && !stop_i && (num_tics_i != '0);
    win_end     = (state_q == StRun) && (cnt_q == n_q - MAX_RSSI_TICS_BW'(1));

    if (reset_15p36) begin
      // State register clears everything; just keep the pulse quiet.
    end else if (stop_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (start_ok) begin
      state_d = StRun;
      n_d     = num_tics_i;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      if (win_end) begin
        rssi_load_o = 1'b1;
        cnt_d       = '0;
        idx_d       = idx_q + WIN_IDX_BW'(1);
        n_d         = num_tics_i;
        if (oneshot_i) begin
          state_d = StDone;
        end else if (num_tics_i == '0) begin
          state_d = StIdle;
        end
      end else if (sync_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + MAX_RSSI_TICS_BW'(1);
      end
    end
  end

  always_ff @(posedge clk_15p36) begin
    if (reset_15p36) begin
      state_q <= StIdle;
      n_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign win_idx_o = idx_q;

endmodule

// File: rtl/jb_xssi_multi_cntr.sv
// NUM_CH independent xSSI window counters sharing one realign pulse.
module jb_xssi_multi_cntr
  import jb_xssi_pkg::*;
#(
  parameter int unsigned NUM_CH           = DefNumCh,
  parameter int unsigned MAX_RSSI_TICS_BW = DefRssiTicsBw,
  parameter int unsigned WIN_IDX_BW       = DefWinIdxBw
) (
  input logic                clk_15p36,
  input logic                reset_15p36,
  jb_xssi_multi_cntr_if.slave bus
);

  logic [NUM_CH-1:0]                 rssi_load;
  logic [NUM_CH-1:0]                 ch_busy;
  logic [NUM_CH-1:0]                 ch_done;
  logic [NUM_CH-1:0][WIN_IDX_BW-1:0] win_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jb_xssi_ch_cntr #(
      .MAX_RSSI_TICS_BW (MAX_RSSI_TICS_BW),
      .WIN_IDX_BW       (WIN_IDX_BW)
    ) u_ch (
      .clk_15p36   (clk_15p36),
      .reset_15p36 (reset_15p36),
      .num_tics_i  (bus.ch_num_tics[g]),
      .oneshot_i   (bus.ch_oneshot[g]),
      .start_i     (bus.ch_start[g]),
      .stop_i      (bus.ch_stop[g]),
      .sync_i      (bus.sync_in),
      .rssi_load_o (rssi_load[g]),
      .busy_o      (ch_busy[g]),
      .done_o      (ch_done[g]),
      .win_idx_o   (win_idx[g])
    );
  end

  assign bus.rssi_load = rssi_load;
  assign bus.ch_busy   = ch_busy;
  assign bus.ch_done   = ch_done;
  assign bus.win_idx   = win_idx;

endmodule

// File: tb/tb_jb_xssi_multi_cntr.sv
// Table-driven bench for jb_xssi_multi_cntr with a per-cycle expectation queue.
module tb_jb_xssi_multi_cntr;

  localparam int unsigned NCH = 4;
  localparam int unsigned TW  = 21;
  localparam int unsigned IW  = 16;

  logic clk_15p36 = 1'b0;
  logic reset_15p36;

  always #5 clk_15p36 = ~clk_15p36;

  jb_xssi_multi_cntr_if #(
    .NUM_CH           (NCH),
    .MAX_RSSI_TICS_BW (TW),
    .WIN_IDX_BW       (IW)
  ) xif ();

  jb_xssi_multi_cntr #(
    .NUM_CH           (NCH),
    .MAX_RSSI_TICS_BW (TW),
    .WIN_IDX_BW       (IW)
  ) dut (
    .clk_15p36   (clk_15p36),
    .reset_15p36 (reset_15p36),
    .bus         (xif)
  );

  // One record = `rep` cycles of the same inputs on channel `ch`; pulses only on the first.
  typedef struct {
    int          ch;
    logic        start, stop, sync, one;
    logic [TW-1:0] tics;
    logic        rst;
    int          rep;
    logic        load, busy, done;
    logic [IW-1:0] idx;
  } vec_t;

  typedef struct {
    int          tag;
    int          ch;
    logic        load, busy, done;
    logic [IW-1:0] idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   got;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t v(int ch, bit st, bit sp, bit sy, bit one, int tics, bit rst,
                             int rep, bit ld, bit bz, bit dn, int idx);
    vec_t r;
    r.ch = ch; r.start = st; r.stop = sp; r.sync = sy; r.one = one;
    r.tics = TW'(tics); r.rst = rst; r.rep = rep;
    r.load = ld; r.busy = bz; r.done = dn; r.idx = IW'(idx);
    return r;
  endfunction

  task automatic drive(input vec_t t, input int tag);
    exp_t x;
    for (int k = 0; k < t.rep; k++) begin
      @(posedge clk_15p36);
      #1;
      xif.ch_num_tics = '0;
      xif.ch_oneshot  = '0;
      xif.ch_start    = '0;
      xif.ch_stop     = '0;
      xif.sync_in     = 1'b0;
      reset_15p36     = t.rst;
      xif.ch_num_tics[t.ch] = t.tics;
      xif.ch_oneshot[t.ch]  = t.one;
      if (k == 0) begin
        xif.ch_start[t.ch] = t.start;
        xif.ch_stop[t.ch]  = t.stop;
        xif.sync_in        = t.sync;
      end
      x.tag = tag; x.ch = t.ch; x.load = t.load; x.busy = t.busy; x.done = t.done; x.idx = t.idx;
      sb.push_back(x);
    end
  endtask

  always @(negedge clk_15p36) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("v%0d rssi_load", e.tag), 64'(xif.rssi_load),
            e.load ? 64'(1) << e.ch : 64'(0));
      check($sformatf("v%0d ch_busy", e.tag), 64'(xif.ch_busy),
            e.busy ? 64'(1) << e.ch : 64'(0));
      check($sformatf("v%0d ch_done", e.tag), 64'(xif.ch_done),
            e.done ? 64'(1) << e.ch : 64'(0));
      check($sformatf("v%0d win_idx", e.tag), 64'(xif.win_idx[e.ch]), 64'(e.idx));
    end
  end

  initial begin
    reset_15p36     = 1'b1;
    xif.ch_num_tics = '0;
    xif.ch_oneshot  = '0;
    xif.ch_start    = '0;
    xif.ch_stop     = '0;
    xif.sync_in     = 1'b0;

    //            ch st sp sy on tic rst rep ld bz dn idx
    // reset state
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // ch0 N=4 periodic: loads at 4, 8, 12; stop on the cycle-16 window end
    vecs.push_back(v(0, 1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 3, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 3, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 3, 0, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 3, 0, 1, 0, 3));
    vecs.push_back(v(0, 0, 1, 0, 0, 4, 0, 1, 0, 1, 0, 3));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 2, 0, 0, 0, 3));
    // ch1 N=3 one-shot, restart from DONE, then stop from DONE
    vecs.push_back(v(1, 1, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 2, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 3, 0, 0, 1, 1));
    vecs.push_back(v(1, 1, 0, 0, 1, 3, 0, 1, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 2, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 1, 0, 1, 3, 0, 1, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 1));
    // ch0 N=8, length 2 from cycle 5: loads 8, 10, 12; then length 0 ends after 14
    vecs.push_back(v(0, 1, 0, 0, 0, 8, 0, 1, 0, 0, 0, 3));
    vecs.push_back(v(0, 0, 0, 0, 0, 8, 0, 4, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 3, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 4));
    // ch2 N=10: sync at 6 moves load to 16; sync on the cycle-26 window end still loads
    vecs.push_back(v(2, 1, 0, 0, 0, 10, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 5, 0, 1, 0, 0));
    vecs.push_back(v(2, 0, 0, 1, 0, 10, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 9, 0, 1, 0, 0));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 9, 0, 1, 0, 1));
    vecs.push_back(v(2, 0, 0, 1, 0, 10, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 9, 0, 1, 0, 2));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 1, 1, 1, 0, 2));
    vecs.push_back(v(2, 0, 1, 0, 0, 10, 0, 1, 0, 1, 0, 3));
    vecs.push_back(v(2, 0, 0, 0, 0, 10, 0, 1, 0, 0, 0, 3));
    // ch3: start+stop together, start with length 0, restart mid-window, N=1
    vecs.push_back(v(3, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 2, 0, 1, 0, 0));
    vecs.push_back(v(3, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 2, 0, 0, 0, 0));
    vecs.push_back(v(3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(v(3, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 2, 0, 1, 0, 0));
    vecs.push_back(v(3, 1, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 4, 0, 1, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(3, 0, 1, 0, 0, 5, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(3, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1));
    vecs.push_back(v(3, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(v(3, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(3, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 2));
    vecs.push_back(v(3, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 3));
    vecs.push_back(v(3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3));
    // ch0 N=5, reset at cycle 3 aborts the window; start is ignored under reset
    vecs.push_back(v(0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 4));
    vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 2, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 3, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i);
    @(negedge clk_15p36);
    #1;

    // Reset must have cleared every channel's window index, not just ch0's.
    check("win_idx_all_after_reset", 64'(xif.win_idx), 64'(0));

    // First-window latency with a bounded wait, then stop holds the index.
    @(posedge clk_15p36);
    #1;
    xif.ch_num_tics[0] = TW'(6);
    xif.ch_start[0]    = 1'b1;
    got = -1;
    for (int n = 1; n <= 20 && got < 0; n++) begin
      @(posedge clk_15p36);
      #1;
      xif.ch_start = '0;
      @(negedge clk_15p36);
      if (xif.rssi_load[0]) got = n;
    end
    check("first_load_latency_n6", 64'(got), 64'(6));
    @(posedge clk_15p36);
    #1;
    xif.ch_stop[0] = 1'b1;
    @(posedge clk_15p36);
    #1;
    xif.ch_stop = '0;
    @(negedge clk_15p36);
    check("busy_after_stop", 64'(xif.ch_busy), 64'(0));
    check("win_idx_held_after_stop", 64'(xif.win_idx[0]), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jb_xssi_multi_cntr.md
JB_XSSI_MULTI_CNTR -- requirements
Module: jb_xssi_multi_cntr

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent xSSI window channels (1..16).
REQ-002 Parameter MAX_RSSI_TICS_BW, default 21, width of the per-channel window length in 15.36 MHz tics.
REQ-003 Parameter WIN_IDX_BW, default 16, width of the per-channel window index counter.
REQ-004 clk_15p36  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_15p36  in  1  synchronous, active-high reset.
REQ-006 ch_num_tics  in  NUM_CH x MAX_RSSI_TICS_BW  requested window length per channel; 0 means disabled.
REQ-007 ch_oneshot  in  NUM_CH  per channel: 0 = periodic windows, 1 = single window then stop.
REQ-008 ch_start  in  NUM_CH  single-cycle start/restart request per channel.
REQ-009 ch_stop  in  NUM_CH  single-cycle stop request per channel.
REQ-010 sync_in  in  1  single-cycle realign pulse, common to all channels.
REQ-011 rssi_load  out  NUM_CH  single-cycle window-end pulse per channel.
REQ-012 ch_busy  out  NUM_CH  channel in RUN state.
REQ-013 ch_done  out  NUM_CH  one-shot window completed; sticky until next start or stop.
REQ-014 win_idx  out  NUM_CH x WIN_IDX_BW  count of completed windows since last start.

Function
REQ-015 Each channel SHALL implement states IDLE, RUN, DONE and SHALL operate independently of other channels except for sync_in.
REQ-016 IDLE -> RUN when ch_start=1, ch_stop=0 and ch_num_tics!=0; ch_start with ch_num_tics=0 SHALL be ignored.
REQ-017 On entry to RUN the channel SHALL latch ch_num_tics as active length N and clear tic counter and win_idx to 0.
REQ-018 In RUN, the first rssi_load SHALL be high exactly N cycles after the cycle in which ch_start was sampled high, then every N cycles.
REQ-019 At each window end the tic counter SHALL wrap to 0, win_idx SHALL increment modulo 2^WIN_IDX_BW, and ch_num_tics SHALL be re-latched as N for the next window.
REQ-020 ch_num_tics changes mid-window SHALL NOT affect the current window; a value of 0 latched at window end SHALL move the channel to IDLE after that window's rssi_load.
REQ-021 N=1 SHALL produce rssi_load high every cycle while in RUN.
REQ-022 ch_oneshot=1: after the first rssi_load the channel SHALL go to DONE with ch_done=1, ch_busy=0, win_idx=1.
REQ-023 ch_stop from RUN or DONE SHALL go to IDLE the next cycle, clear ch_done, hold win_idx, and suppress any rssi_load for that cycle.
REQ-024 ch_start and ch_stop simultaneous: ch_stop SHALL win.
REQ-025 ch_start in RUN or DONE SHALL restart per REQ-017 and clear ch_done; no rssi_load SHALL be issued for the aborted window.
REQ-026 sync_in in RUN SHALL reset the tic counter to 0 without issuing rssi_load or changing win_idx; the next rssi_load follows N cycles after sync_in.
REQ-027 sync_in coincident with a window end SHALL let that rssi_load issue and restart counting from 0.
REQ-028 sync_in SHALL have no effect on IDLE or DONE channels.

Reset
REQ-029 reset_15p36 SHALL force all channels to IDLE with rssi_load=0, ch_busy=0, ch_done=0, win_idx=0, tic counters 0, latched N=0.
REQ-030 Reset asserted mid-window SHALL abort without any rssi_load; all inputs SHALL be ignored while reset is high.

Structure
REQ-031 Package jb_xssi_pkg SHALL hold the channel state enum (IDLE/RUN/DONE) and default width constants.
REQ-032 Per-channel logic SHALL be sub-module jb_xssi_ch_cntr, instantiated NUM_CH times by generate; top level only distributes sync_in and packs outputs.

Verification
REQ-033 ch0 N=4 periodic, start at cycle 0 -> rssi_load[0] at cycles 4,8,12; win_idx 1,2,3.
REQ-034 ch1 N=3 one-shot, start at cycle 0 -> single load at cycle 3; ch_done=1, ch_busy=0, win_idx=1; restart clears ch_done.
REQ-035 ch0 N=8 running, ch_num_tics changed to 2 at cycle 5 -> loads at 8, 10, 12.
REQ-036 ch0 N=10, sync_in at cycle 6 -> no load at 10; next load at cycle 16; win_idx unchanged by sync_in.
REQ-037 ch_start and ch_stop together in RUN -> IDLE, no load; ch_start with N=0 -> stays IDLE.
REQ-038 reset_15p36 at cycle 3 of an N=5 window -> all outputs 0 from next cycle; no load at cycle 5.
